// File: rtl/fetch_stage_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fetch_stage_if : F->D pipeline bundle (instruction, PC, exc, slot)   |
// | Revision 1.0                                                         |
// +--------------------------------------------------------------------+
interface fetch_stage_if;
  logic [31:0] Instr_F;
  logic [31:0] pc_F;
  logic [4:0]  EXCode_F;
  logic        ISDB_F;

  modport master (
    output Instr_F,
    output pc_F,
    output EXCode_F,
    output ISDB_F
  );

  modport slave (
    input Instr_F,
    input pc_F,
    input EXCode_F,
    input ISDB_F
  );
endinterface
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fetch_stage : PC register, next-PC select, AdEL detect, fetch count  |
// | Revision 1.0                                                         |
// +--------------------------------------------------------------------+
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
  parameter logic [31:0] IM_LO      = 32'h0000_3000,
  parameter logic [31:0] IM_HI      = 32'h0000_6FFF
) (
  input  wire logic        clk,
  input  wire logic        reset,
  input  wire logic        Req,
  input  wire logic        stall,
  input  wire logic        eret_D,
  input  wire logic [31:0] epc,
  input  wire logic        branch_taken_D,
  input  wire logic [31:0] branch_target_D,
  input  wire logic        is_jump_D,
  input  wire logic [31:0] i_inst_rdata,
  output      logic [31:0] i_inst_addr,
  fetch_stage_if.master    fd,
  output      logic [31:0] fetch_cnt
);

  localparam logic [4:0] EXC_ADEL = 5'd4;

  logic [31:0] pc_q;
  logic [31:0] pc_d;
  logic [31:0] cnt_q;
  logic [31:0] cnt_d;
  logic        fault;

  // Req beats stall so an interrupt can never be masked by a hazard hold.
  always_comb begin
    pc_d  = pc_q + 32'd4;
    cnt_d = cnt_q + 32'd1;
    if (Req) begin
      pc_d  = HANDLER_PC;
      cnt_d = cnt_q;
    end else if (stall) begin
      pc_d  = pc_q;
      cnt_d = cnt_q;
    end else if (eret_D) begin
      pc_d  = epc;
    end else if (branch_taken_D) begin
      pc_d  = branch_target_D;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q  <= RESET_PC;
      cnt_q <= 32'd0;
    end else begin
      pc_q  <= pc_d;
      cnt_q <= cnt_d;
    end
  end

  // Redirect targets are only checked once they become the fetch PC.
  always_comb begin
    fault = (pc_q[1:0] != 2'b00) || (pc_q < IM_LO) || (pc_q > IM_HI);
  end

  always_comb begin
    i_inst_addr = pc_q;
    fd.pc_F     = pc_q;
    fd.Instr_F  = fault ? 32'h0 : i_inst_rdata;
    fd.EXCode_F = fault ? EXC_ADEL : 5'd0;
    fd.ISDB_F   = is_jump_D & ~eret_D;
    fetch_cnt   = cnt_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_fetch_stage : directed vector bench for fetch_stage               |
// | Revision 1.0                                                         |
// +--------------------------------------------------------------------+
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        Req;
  logic        stall;
  logic        eret_D;
  logic [31:0] epc;
  logic        branch_taken_D;
  logic [31:0] branch_target_D;
  logic        is_jump_D;
  logic [31:0] i_inst_rdata;
  logic [31:0] i_inst_addr;
  logic [31:0] fetch_cnt;

  fetch_stage_if fd_if ();

  fetch_stage dut (
    .clk             (clk),
    .reset           (reset),
    .Req             (Req),
    .stall           (stall),
    .eret_D          (eret_D),
    .epc             (epc),
    .branch_taken_D  (branch_taken_D),
    .branch_target_D (branch_target_D),
    .is_jump_D       (is_jump_D),
    .i_inst_rdata    (i_inst_rdata),
    .i_inst_addr     (i_inst_addr),
    .fd              (fd_if),
    .fetch_cnt       (fetch_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  assign i_inst_rdata = mem_word(i_inst_addr);

  typedef struct {
    logic        stall;
    logic        req;
    logic        eret;
    logic        br;
    logic        jmp;
    logic [31:0] tgt;
    logic [31:0] epc;
    logic [31:0] exp_pc;
    logic [31:0] exp_cnt;
    logic [4:0]  exp_exc;
    logic        exp_isdb;
  } vec_t;

  localparam int NV = 22;
  vec_t vecs [NV];

  int passed = 0;
  int total  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic chk_state(input string tag, input logic [31:0] pc, input logic [31:0] cnt,
                           input logic [4:0] exc, input logic isdb);
    chk({tag, " pc_F"}, fd_if.pc_F, pc);
    chk({tag, " i_inst_addr"}, i_inst_addr, pc);
    chk({tag, " fetch_cnt"}, fetch_cnt, cnt);
    chk({tag, " EXCode_F"}, {27'd0, fd_if.EXCode_F}, {27'd0, exc});
    chk({tag, " ISDB_F"}, {31'd0, fd_if.ISDB_F}, {31'd0, isdb});
    chk({tag, " Instr_F"}, fd_if.Instr_F, (exc != 5'd0) ? 32'h0 : mem_word(pc));
  endtask

  task automatic drive(input logic s, input logic r, input logic e, input logic b,
                       input logic j, input logic [31:0] t, input logic [31:0] ep);
    stall = s; Req = r; eret_D = e; branch_taken_D = b;
    is_jump_D = j; branch_target_D = t; epc = ep;
  endtask

  initial begin
    //            st rq er br jm target         epc            exp_pc         cnt    exc  isdb
    vecs[0]  = '{0, 0, 0, 0, 0, 32'h0,         32'h0,         32'h0000_3000, 32'd0,  5'd0, 1'b0};
    vecs[1]  = '{0, 0, 0, 0, 0, 32'h0,         32'h0,         32'h0000_3004, 32'd1,  5'd0, 1'b0};
    vecs[2]  = '{0, 0, 0, 0, 0, 32'h0,         32'h0,         32'h0000_3008, 32'd2,  5'd0, 1'b0};
    vecs[3]  = '{0, 0, 0, 0, 0, 32'h0,         32'h0,         32'h0000_300C, 32'd3,  5'd0, 1'b0};
    vecs[4]  = '{1, 0, 0, 1, 1, 32'h0000_3400, 32'h0,         32'h0000_3010, 32'd4,  5'd0, 1'b1};
    vecs[5]  = '{1, 0, 0, 1, 1, 32'h0000_3400, 32'h0,         32'h0000_3010, 32'd4,  5'd0, 1'b1};
    vecs[6]  = '{0, 0, 0, 1, 1, 32'h0000_3400, 32'h0,         32'h0000_3010, 32'd4,  5'd0, 1'b1};
    vecs[7]  = '{0, 0, 0, 1, 1, 32'h0000_3002, 32'h0,         32'h0000_3400, 32'd5,  5'd0, 1'b1};
    vecs[8]  = '{0, 0, 0, 0, 0, 32'h0,         32'h0,         32'h0000_3002, 32'd6,  5'd4, 1'b0};
    vecs[9]  = '{0, 0, 0, 1, 0, 32'h0000_3020, 32'h0,         32'h0000_3006, 32'd7,  5'd4, 1'b0};
    vecs[10] = '{1, 1, 1, 0, 0, 32'h0,         32'h0000_3050, 32'h0000_3020, 32'd8,  5'd0, 1'b0};
    vecs[11] = '{0, 0, 1, 0, 1, 32'h0,         32'h0000_3050, 32'h0000_4180, 32'd8,  5'd0, 1'b0};
    vecs[12] = '{0, 0, 1, 1, 0, 32'h0000_3400, 32'h0000_3100, 32'h0000_3050, 32'd9,  5'd0, 1'b0};
    vecs[13] = '{0, 0, 0, 1, 0, 32'h0000_6FFC, 32'h0,         32'h0000_3100, 32'd10, 5'd0, 1'b0};
    vecs[14] = '{0, 0, 0, 0, 0, 32'h0,         32'h0,         32'h0000_6FFC, 32'd11, 5'd0, 1'b0};
    vecs[15] = '{0, 0, 0, 0, 0, 32'h0,         32'h0,         32'h0000_7000, 32'd12, 5'd4, 1'b0};
    vecs[16] = '{0, 1, 0, 0, 0, 32'h0,         32'h0,         32'h0000_7004, 32'd13, 5'd4, 1'b0};
    vecs[17] = '{1, 0, 0, 0, 0, 32'h0,         32'h0,         32'h0000_4180, 32'd13, 5'd0, 1'b0};
    vecs[18] = '{0, 0, 0, 1, 0, 32'h0000_2FFC, 32'h0,         32'h0000_4180, 32'd13, 5'd0, 1'b0};
    vecs[19] = '{0, 0, 0, 1, 0, 32'hFFFF_FFFC, 32'h0,         32'h0000_2FFC, 32'd14, 5'd4, 1'b0};
    vecs[20] = '{0, 0, 0, 0, 0, 32'h0,         32'h0,         32'hFFFF_FFFC, 32'd15, 5'd4, 1'b0};
    vecs[21] = '{1, 0, 0, 0, 0, 32'h0,         32'h0,         32'h0000_0000, 32'd16, 5'd4, 1'b0};

    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].stall, vecs[i].req, vecs[i].eret, vecs[i].br,
            vecs[i].jmp, vecs[i].tgt, vecs[i].epc);
      #1;
      chk_state($sformatf("vec%0d", i), vecs[i].exp_pc, vecs[i].exp_cnt,
                vecs[i].exp_exc, vecs[i].exp_isdb);
      @(negedge clk);
    end

    // Reset asserted while a stall and a branch are both pending.
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_3400, 32'h0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    chk_state("mid_reset", 32'h0000_3000, 32'd0, 5'd0, 1'b0);
    @(negedge clk);
    #1;
    chk_state("post_reset", 32'h0000_3004, 32'd1, 5'd0, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
